// File: rtl/fp_int_converter_pipe_if.sv
// Handshake/operand/result bundle for fp_int_converter_pipe.
// Use the master modport on the producer/consumer side and the slave modport on the converter.
interface fp_int_converter_pipe_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned INT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   x;
  logic                   is_unsigned;
  logic                   rnd_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [INT_W-1:0]       r;
  logic                   negative;
  logic                   zero;
  logic                   overflow;
  logic                   inexact;
  logic                   inf;
  logic                   nan;
  logic                   subnormal;

  modport master (
    output in_valid, x, is_unsigned, rnd_mode, out_ready,
    input  in_ready, out_valid, r, negative, zero, overflow, inexact, inf, nan, subnormal
  );

  modport slave (
    input  in_valid, x, is_unsigned, rnd_mode, out_ready,
    output in_ready, out_valid, r, negative, zero, overflow, inexact, inf, nan, subnormal
  );
endinterface

// File: rtl/fp_int_converter_pipe.sv
// 3-stage float -> signed/unsigned integer converter with saturation and exception flags.
// Define ROUND_NEAREST_EN to honour rnd_mode (round-nearest-even); otherwise always truncates.
module fp_int_converter_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned INT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  fp_int_converter_pipe_if.slave bus
);

  localparam int          BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned FW   = MAN_W + INT_W;
  localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } cls_t;

  logic adv;
  assign adv         = ~(bus.out_valid & ~bus.out_ready);
  assign bus.in_ready = adv;

  // ---------------- stage 1: classify / unbias ----------------
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  cls_t             in_cls;
  logic signed [EXP_W:0] in_e;

  assign {in_sign, in_exp, in_man} = bus.x;
  assign in_e = $signed({1'b0, in_exp}) - $signed((EXP_W+1)'(BIAS));

  always_comb begin
    in_cls = CLS_NORM;
    if (in_exp == '0)      in_cls = (in_man == '0) ? CLS_ZERO : CLS_SUB;
    else if (in_exp == '1) in_cls = (in_man == '0) ? CLS_INF  : CLS_NAN;
  end

  logic                  s1_valid, s1_sign, s1_uns;
  cls_t                  s1_cls;
  logic signed [EXP_W:0] s1_e;
  logic [MAN_W-1:0]      s1_man;
`ifdef ROUND_NEAREST_EN
  logic                  s1_rnd, s2_rnd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_uns   <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_e     <= '0;
      s1_man   <= '0;
`ifdef ROUND_NEAREST_EN
      s1_rnd   <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= in_sign;
      s1_uns   <= bus.is_unsigned;
      s1_cls   <= in_cls;
      s1_e     <= in_e;
      s1_man   <= in_man;
`ifdef ROUND_NEAREST_EN
      s1_rnd   <= bus.rnd_mode;
`endif
    end
  end

  // ---------------- stage 2: align ----------------
  // Left/right alignment folded into one left shift of {1,man} by e into a fixed-point
  // word with MAN_W fraction bits; e >= INT_W can never fit and is flagged as big.
  int              e_i;
  logic [FW-1:0]   full;
  logic            a_big, a_guard, a_sticky;
  logic [INT_W-1:0] a_mag;

  always_comb begin
    e_i      = int'(s1_e);
    full     = '0;
    a_big    = 1'b0;
    a_mag    = '0;
    a_guard  = 1'b0;
    a_sticky = 1'b0;
    if (e_i >= int'(INT_W)) begin
      a_big = 1'b1;
    end else if (e_i >= 0) begin
      full     = FW'({1'b1, s1_man}) << e_i;
      a_mag    = full[MAN_W +: INT_W];
      a_guard  = full[MAN_W-1];
      a_sticky = |full[MAN_W-2:0];
    end else begin
      a_guard  = (e_i == -1);
      a_sticky = (e_i < -1) | (|s1_man);
    end
  end

  logic             s2_valid, s2_sign, s2_uns, s2_big, s2_guard, s2_sticky;
  cls_t             s2_cls;
  logic [INT_W-1:0] s2_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_uns    <= 1'b0;
      s2_big    <= 1'b0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_cls    <= CLS_ZERO;
      s2_mag    <= '0;
`ifdef ROUND_NEAREST_EN
      s2_rnd    <= 1'b0;
`endif
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_uns    <= s1_uns;
      s2_big    <= a_big;
      s2_guard  <= a_guard;
      s2_sticky <= a_sticky;
      s2_cls    <= s1_cls;
      s2_mag    <= a_mag;
`ifdef ROUND_NEAREST_EN
      s2_rnd    <= s1_rnd;
`endif
    end
  end

  // ---------------- stage 3: round / saturate / sign ----------------
  logic             rnd_up, ovf, inex;
  logic [INT_W:0]   rmag;
  logic [INT_W-1:0] res;

  always_comb begin
    rnd_up = 1'b0;
`ifdef ROUND_NEAREST_EN
    rnd_up = s2_rnd & s2_guard & (s2_sticky | s2_mag[0]);
`endif
    rmag = {1'b0, s2_mag} + {{INT_W{1'b0}}, rnd_up};
    res  = '0;
    ovf  = 1'b0;
    inex = 1'b0;
    case (s2_cls)
      CLS_ZERO: ;
      CLS_SUB:  inex = 1'b1;
      CLS_INF: begin
        ovf = 1'b1;
        if (s2_uns) res = s2_sign ? '0 : '1;
        else        res = s2_sign ? SMIN : SMAX;
      end
      CLS_NAN: begin
        ovf = 1'b1;
        res = s2_uns ? '1 : SMAX;
      end
      default: begin
        inex = s2_guard | s2_sticky;
        if (s2_uns) begin
          if (s2_sign) begin
            ovf = s2_big | (|rmag);
          end else if (s2_big | rmag[INT_W]) begin
            ovf = 1'b1;
            res = '1;
          end else begin
            res = rmag[INT_W-1:0];
          end
        end else if (s2_sign) begin
          // magnitude exactly 2^(INT_W-1) is representable when negative
          if (s2_big | (rmag > {1'b0, SMIN})) begin
            ovf = 1'b1;
            res = SMIN;
          end else begin
            res = '0 - rmag[INT_W-1:0];
          end
        end else if (s2_big | (rmag > {1'b0, SMAX})) begin
          ovf = 1'b1;
          res = SMAX;
        end else begin
          res = rmag[INT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.r         <= '0;
      bus.negative  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.inexact   <= 1'b0;
      bus.inf       <= 1'b0;
      bus.nan       <= 1'b0;
      bus.subnormal <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s2_valid;
      bus.r         <= s2_valid ? res : '0;
      bus.negative  <= s2_valid & ~s2_uns & res[INT_W-1];
      bus.zero      <= s2_valid & ~(|res);
      bus.overflow  <= s2_valid & ovf;
      bus.inexact   <= s2_valid & inex;
      bus.inf       <= s2_valid & (s2_cls == CLS_INF);
      bus.nan       <= s2_valid & (s2_cls == CLS_NAN);
      bus.subnormal <= s2_valid & (s2_cls == CLS_SUB);
    end
  end

endmodule

// File: tb/tb_fp_int_converter_pipe.sv
// Self-checking bench for fp_int_converter_pipe (half precision -> 16-bit integer).
// Expected values adapt to ROUND_NEAREST_EN when the bench is built with that macro.
module tb_fp_int_converter_pipe;

`ifdef ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] x;
    logic        uns;
    logic        rnd;
    logic [15:0] r;
    logic [6:0]  fl;  // {negative, zero, overflow, inexact, inf, nan, subnormal}
  } vec_t;

  typedef struct {
    logic [15:0] r;
    logic [6:0]  fl;
    int          acc;
    int          id;
  } sb_t;

  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   n_out  = 0;
  bit   lat_chk = 1'b0;
  vec_t tbl [NV];
  vec_t cur;
  int   cur_id;
  sb_t  q [$];

  fp_int_converter_pipe_if #(.EXP_W(5), .MAN_W(10), .INT_W(16)) bus ();

  fp_int_converter_pipe #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic logic [6:0] act_flags();
    return {bus.negative, bus.zero, bus.overflow, bus.inexact, bus.inf, bus.nan, bus.subnormal};
  endfunction

  // scoreboard: compare head while valid (also proves stall stability), pop on consume
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end else begin
          chk($sformatf("r[%0d]", q[0].id), {16'b0, bus.r}, {16'b0, q[0].r});
          chk($sformatf("flags[%0d]", q[0].id), {25'b0, act_flags()}, {25'b0, q[0].fl});
          if (bus.out_ready) begin
            if (lat_chk) chk($sformatf("latency[%0d]", q[0].id), cyc - q[0].acc, 3);
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back('{r: cur.r, fl: cur.fl, acc: cyc, id: cur_id});
    end
  end

  task automatic send(input vec_t v, input int id);
    bit acc;
    int n;
    cur             = v;
    cur_id          = id;
    bus.in_valid    = 1'b1;
    bus.x           = v.x;
    bus.is_unsigned = v.uns;
    bus.rnd_mode    = v.rnd;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk($sformatf("accept_timeout[%0d]", id), 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({nm, "_r"}, {16'b0, bus.r}, 32'd0);
    chk({nm, "_flags"}, {25'b0, act_flags()}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    tbl[0]  = '{16'h4A40, 1'b0, 1'b0, 16'h000C, 7'b0001000};
    tbl[1]  = '{16'h4AC0, 1'b0, 1'b1, RNE ? 16'h000E : 16'h000D, 7'b0001000};
    tbl[2]  = '{16'h4A40, 1'b0, 1'b1, 16'h000C, 7'b0001000};
    tbl[3]  = '{16'hF800, 1'b0, 1'b0, 16'h8000, 7'b1000000};
    tbl[4]  = '{16'h7800, 1'b0, 1'b0, 16'h7FFF, 7'b0010000};
    tbl[5]  = '{16'h7C00, 1'b0, 1'b0, 16'h7FFF, 7'b0010100};
    tbl[6]  = '{16'hFC00, 1'b0, 1'b0, 16'h8000, 7'b1010100};
    tbl[7]  = '{16'h7E00, 1'b0, 1'b0, 16'h7FFF, 7'b0010010};
    tbl[8]  = '{16'h0001, 1'b0, 1'b0, 16'h0000, 7'b0101001};
    tbl[9]  = '{16'h8000, 1'b0, 1'b0, 16'h0000, 7'b0100000};
    tbl[10] = '{16'hBC00, 1'b1, 1'b0, 16'h0000, 7'b0110000};
    tbl[11] = '{16'hB400, 1'b1, 1'b0, 16'h0000, 7'b0101000};
    tbl[12] = '{16'h7BFF, 1'b1, 1'b0, 16'hFFE0, 7'b0000000};
    tbl[13] = '{16'hC200, 1'b0, 1'b0, 16'hFFFD, 7'b1000000};
    tbl[14] = '{16'h3C00, 1'b0, 1'b0, 16'h0001, 7'b0000000};
    tbl[15] = '{16'h3800, 1'b0, 1'b1, 16'h0000, 7'b0101000};
    tbl[16] = '{16'h3E00, 1'b0, 1'b1, RNE ? 16'h0002 : 16'h0001, 7'b0001000};
    tbl[17] = '{16'h7BFF, 1'b0, 1'b0, 16'h7FFF, 7'b0010000};
    tbl[18] = '{16'hFC00, 1'b1, 1'b0, 16'h0000, 7'b0110100};
    tbl[19] = '{16'h7E00, 1'b1, 1'b0, 16'hFFFF, 7'b0010010};
    tbl[20] = '{16'hBA00, 1'b1, 1'b1, 16'h0000, RNE ? 7'b0111000 : 7'b0101000};
    tbl[21] = '{16'hF801, 1'b0, 1'b0, 16'h8000, 7'b1010000};
    tbl[22] = '{16'h0001, 1'b0, 1'b1, 16'h0000, 7'b0101001};
    tbl[23] = '{16'h7C00, 1'b1, 1'b0, 16'hFFFF, 7'b0010100};
    tbl[24] = '{16'h5BFF, 1'b1, 1'b1, RNE ? 16'h0100 : 16'h00FF, 7'b0001000};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.x           = '0;
    bus.is_unsigned = 1'b0;
    bus.rnd_mode    = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back table with out_ready held high: results and exact 3-cycle latency
    lat_chk = 1'b1;
    for (int i = 0; i < NV; i++) send(tbl[i], i);
    bus.in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;

    // stream of 6 with a 4-cycle downstream stall in the middle
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(tbl[i + 3], 100 + i);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", n_out - n0, 6);

    // reset with operands in flight: cleared immediately, nothing emitted afterwards
    n0 = n_out;
    send(tbl[4], 200);
    send(tbl[5], 201);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk_cleared("reset_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_outputs", n_out - n0, 0);
    chk_cleared("post_reset_idle");

    send(tbl[13], 300);
    bus.in_valid = 1'b0;
    drain();
    chk("post_reset_recovery", n_out - n0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fp_int_converter_pipe.md
Name: fp_int_converter_pipe

Overview:
Parametrised, pipelined successor to the combinational half-precision-to-int16 converter. Converts an IEEE-754-style float (EXP_W/MAN_W) to a signed or unsigned INT_W-bit integer. Fixed 3-stage pipeline with valid/ready handshake, saturation and full exception flags. Sits between the FP datapath and the integer ALU result mux.

Parameters:
EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 10, stored mantissa width (implicit leading 1 for normals)
INT_W, 16, integer result width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept operand this cycle
x  input  1+EXP_W+MAN_W  float operand {sign, exp, man}
is_unsigned  input  1  1: unsigned target; 0: two's-complement target
rnd_mode  input  1  0: truncate toward zero; 1: round-nearest-even (see Optional Feature)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
r  output  INT_W  integer result
negative  output  1  r[INT_W-1] in signed mode; 0 in unsigned mode
zero  output  1  r == 0
overflow  output  1  result saturated (out of range, inf, nan)
inexact  output  1  nonzero fraction bits discarded
inf  output  1  operand was +/-infinity
nan  output  1  operand was NaN
subnormal  output  1  operand was subnormal

Behaviour:
- Reset: all stage valids 0, out_valid 0, r 0, all flags 0. Reset mid-operation discards in-flight data; nothing emitted afterwards.
- Handshake: transfer on in_valid & in_ready; output consumed on out_valid & out_ready. Global stall: in_ready = ~(out_valid & ~out_ready). While stalled all stages, r and flags hold stable.
- Latency exactly 3 cycles with out_ready high; throughput 1/cycle. Bubbles propagate (valid bit per stage).
- Stage 1 (classify/latch): capture x, is_unsigned, rnd_mode. Classes: zero (exp=0, man=0); subnormal (exp=0, man!=0); inf (exp all-1, man=0); nan (exp all-1, man!=0); normal otherwise. e = exp - bias (signed, EXP_W+1 bits).
- Stage 2 (align): magnitude {1,man} shifted left by e-MAN_W if e>=MAN_W, else right by MAN_W-e; keep guard bit and sticky OR of bits below guard. e<0: integer part 0, guard = (e==-1), sticky = (e<-1) | (man!=0).
- Stage 3 (round/saturate/sign):
  - truncate: no increment. RNE: increment if guard & (sticky | lsb). Carry out of rounding is an overflow.
  - inexact = guard | sticky (normals); 1 for subnormals; 0 for zero/inf/nan.
  - Signed range [-2^(INT_W-1), 2^(INT_W-1)-1]. Magnitude 2^(INT_W-1) with sign 1 is exact, no overflow (r = 0x8000 at INT_W=16).
  - Unsigned range [0, 2^INT_W-1]. Negative operand whose rounded magnitude is nonzero -> r=0, overflow=1. Rounding to 0 -> r=0, no overflow.
  - Overflow saturation: signed -> 2^(INT_W-1)-1 if positive, -2^(INT_W-1) if negative; unsigned -> all-ones if positive.
  - inf: saturate by sign as above; inf=1, overflow=1. nan: signed max positive, unsigned all-ones; nan=1, overflow=1.
  - zero / -0: r=0, negative=0. subnormal: r=0 (truncate, or RNE), subnormal=1, inexact=1.
- Flags are registered with r and valid only when out_valid=1.

Optional Feature:
ROUND_NEAREST_EN: defined -> rnd_mode honoured, RNE logic built. Undefined -> rnd_mode ignored, always truncate, guard/sticky used only for inexact.

Test Plan:
- Signed, truncate, x=0x4A40 (12.5) -> r=0x000C, inexact=1, 3 cycles after accept.
- Signed, RNE, x=0x4AC0 (13.5) -> r=0x000E, inexact=1; x=0x4A40 -> r=0x000C (tie to even).
- Signed, x=0xF800 (-32768) -> r=0x8000, overflow=0, negative=1; x=0x7800 (32768) -> r=0x7FFF, overflow=1.
- Specials, signed: 0x7C00 -> 0x7FFF, inf=1; 0xFC00 -> 0x8000, inf=1; 0x7E00 -> 0x7FFF, nan=1; 0x0001 -> 0, subnormal=1; 0x8000 -> 0, zero=1, negative=0.
- Unsigned: 0xBC00 (-1.0) -> r=0, overflow=1; 0xB400 (-0.25) truncate -> r=0, overflow=0, inexact=1; 0x7BFF (65504) -> 0xFFE0.
- Back-to-back stream of 6 operands, out_ready low for 4 cycles mid-stream, then rst pulse mid-stream -> no loss/duplication, r stable while stalled, outputs cleared and nothing emitted after rst.
